// File: rtl/delay_align_if.sv
// delay_align_if: stream/status bundle between the lab top level and
// delay_align_detector. The master drives both data streams and the start
// pulse; the slave (the detector) returns its estimate and status.
interface delay_align_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ref_d;      // undelayed source data
  logic [WIDTH-1:0] dly_d;      // delay line output under test
  logic             start;      // single-cycle search (re)start pulse
  logic [1:0]       delay_est;  // detected tap delay, valid while locked
  logic             locked;     // alignment established
  logic             busy;       // search in progress
  logic             fail;       // no candidate matched, sticky
  logic [7:0]       err_cnt;    // saturating mismatch count while locked

  modport master (
    output ref_d, dly_d, start,
    input  delay_est, locked, busy, fail, err_cnt
  );

  modport slave (
    input  ref_d, dly_d, start,
    output delay_est, locked, busy, fail, err_cnt
  );
endinterface

// File: rtl/delay_align_detector.sv
// delay_align_detector: works out which tap (0..3 cycles) of the
// selectable-latency delay line is in effect by comparing its output with
// delayed copies of the source stream, locks to it and keeps watching for
// misalignment.
// Optional feature macro: DELAY_ALIGN_ERRCNT_EN builds the saturating
// err_cnt register; without it err_cnt is tied to zero.
module delay_align_detector #(
  parameter int WIDTH     = 8,
  parameter int MATCH_LEN = 4,  // consecutive matches needed to lock (1..15)
  parameter int LOSS_LEN  = 2   // consecutive mismatches that drop lock (1..15)
) (
  input logic         clk,
  input logic         rst,
  delay_align_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t           state;
  logic [1:0]       cand;       // candidate tap under test
  logic [3:0]       mcnt;       // consecutive matches in SEARCH
  logic [3:0]       lcnt;       // consecutive mismatches in LOCKED
  logic [1:0]       delay_est_q;
  logic             locked_q;
  logic             busy_q;
  logic             fail_q;

  logic [WIDTH-1:0] h1, h2, h3; // ref_d delayed by 1, 2, 3 cycles
  logic [1:0]       sel;
  logic [WIDTH-1:0] tap;
  logic             match;
  logic [3:0]       mcnt_inc;
  logic [3:0]       lcnt_inc;

  localparam logic [3:0] MATCH_LEN_C = 4'(MATCH_LEN);
  localparam logic [3:0] LOSS_LEN_C  = 4'(LOSS_LEN);

  // Source history shift register, advanced every cycle.
  // NOTE: non-blocking assignments make h1->h2->h3 shift by one stage per
  // edge; blocking ones would collapse the chain into a single register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else begin
      h1 <= bus.ref_d;
      h2 <= h1;
      h3 <= h2;
    end
  end

  // Select the tap under test: the locked delay when locked, else the candidate.
  // NOTE: tap gets a default before the case so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    sel = (state == S_LOCKED) ? delay_est_q : cand;
    tap = bus.ref_d;
    case (sel)
      2'd1:    tap = h1;
      2'd2:    tap = h2;
      2'd3:    tap = h3;
      default: tap = bus.ref_d;
    endcase
  end

  assign match    = (bus.dly_d == tap);
  assign mcnt_inc = mcnt + 4'd1;
  assign lcnt_inc = lcnt + 4'd1;

  // Search / lock FSM with registered status outputs; start has top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cand        <= 2'd0;
      mcnt        <= 4'd0;
      lcnt        <= 4'd0;
      delay_est_q <= 2'd0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (bus.start) begin
      state    <= S_SEARCH;
      cand     <= 2'd0;
      mcnt     <= 4'd0;
      lcnt     <= 4'd0;
      locked_q <= 1'b0;
      busy_q   <= 1'b1;
      fail_q   <= 1'b0;
    end else begin
      case (state)
        S_SEARCH: begin
          if (match) begin
            if (mcnt_inc == MATCH_LEN_C) begin
              state       <= S_LOCKED;
              delay_est_q <= cand;
              mcnt        <= 4'd0;
              locked_q    <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              mcnt <= mcnt_inc;
            end
          end else begin
            mcnt <= 4'd0;
            if (cand == 2'd3) begin
              state  <= S_FAIL;
              busy_q <= 1'b0;
              fail_q <= 1'b1;
            end else begin
              cand <= cand + 2'd1;
            end
          end
        end
        S_LOCKED: begin
          if (!match) begin
            if (lcnt_inc == LOSS_LEN_C) begin
              state    <= S_SEARCH;
              cand     <= 2'd0;
              mcnt     <= 4'd0;
              lcnt     <= 4'd0;
              locked_q <= 1'b0;
              busy_q   <= 1'b1;
            end else begin
              lcnt <= lcnt_inc;
            end
          end else begin
            lcnt <= 4'd0;
          end
        end
        default: ; // IDLE and FAIL wait for start
      endcase
    end
  end

  assign bus.delay_est = delay_est_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = busy_q;
  assign bus.fail      = fail_q;

`ifdef DELAY_ALIGN_ERRCNT_EN
  logic [7:0] err_q;

  // Count mismatches seen while locked, saturating; cleared only by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 8'h00;
    end else if (bus.start) begin
      err_q <= 8'h00;
    end else if (state == S_LOCKED && !match && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_delay_align_detector.sv
// tb_delay_align_detector: directed self-checking bench for
// delay_align_detector with default parameters. The source stream counts
// up every cycle; dly_d is built from the bench's own copy of the source
// history at a chosen delay, optionally corrupted or forced constant.
module tb_delay_align_detector;

`ifdef DELAY_ALIGN_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  delay_align_if #(.WIDTH(8)) bus ();

  delay_align_detector #(
    .WIDTH    (8),
    .MATCH_LEN(4),
    .LOSS_LEN (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] hist1, hist2, hist3;
  int         cur_dly;
  bit         fixed_aa;
  bit         corrupt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_err(input int n);
    if (!ERR_EN) return 8'h00;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic drive_dly();
    logic [7:0] tap;
    case (cur_dly)
      1:       tap = hist1;
      2:       tap = hist2;
      3:       tap = hist3;
      default: tap = bus.ref_d;
    endcase
    if (fixed_aa)     bus.dly_d = 8'hAA;
    else if (corrupt) bus.dly_d = tap ^ 8'hFF;
    else              bus.dly_d = tap;
  endtask

  // One clock: wait past the edge, advance the source model, redrive dly_d.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      hist1 = 8'h00;
      hist2 = 8'h00;
      hist3 = 8'h00;
    end else begin
      hist3 = hist2;
      hist2 = hist1;
      hist1 = bus.ref_d;
    end
    bus.ref_d = bus.ref_d + 8'd1;
    drive_dly();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse start so that the next edge (E0) samples it, with a new delay setting.
  task automatic pulse_start(input int dly, input bit aa);
    cur_dly    = dly;
    fixed_aa   = aa;
    corrupt    = 1'b0;
    bus.start  = 1'b1;
    drive_dly();
    tick();
    bus.start  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.ref_d = 8'h00;
    bus.dly_d = 8'h00;
    bus.start = 1'b0;
    hist1     = 8'h00;
    hist2     = 8'h00;
    hist3     = 8'h00;
    cur_dly   = 0;
    fixed_aa  = 1'b0;
    corrupt   = 1'b0;

    #2;
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_fail",   32'(bus.fail),   32'd0);
    check("rst_est",    32'(bus.delay_est), 32'd0);
    check("rst_err",    32'(bus.err_cnt),   32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(5);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Delay 0: best-case lock at E0+4, busy high for four cycles.
    pulse_start(0, 1'b0);
    check("d0_busy_e0", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("d0_busy", 32'(bus.busy), 32'd1);
    end
    tick();
    check("d0_locked", 32'(bus.locked), 32'd1);
    check("d0_est",    32'(bus.delay_est), 32'd0);
    check("d0_busy_off", 32'(bus.busy), 32'd0);

    // Delay 2: k=0 and k=1 fail once each, four matches lock at E0+6.
    pulse_start(2, 1'b0);
    check("d2_locked_clr", 32'(bus.locked), 32'd0);
    ticks(5);
    check("d2_not_yet", 32'(bus.locked), 32'd0);
    check("d2_nofail",  32'(bus.fail),   32'd0);
    tick();
    check("d2_locked", 32'(bus.locked), 32'd1);
    check("d2_est",    32'(bus.delay_est), 32'd2);
    check("d2_fail",   32'(bus.fail), 32'd0);

    // No match: all four taps fail, fail rises at E0+4 and is sticky.
    pulse_start(0, 1'b1);
    ticks(3);
    check("nm_fail_early", 32'(bus.fail), 32'd0);
    tick();
    check("nm_fail",  32'(bus.fail), 32'd1);
    check("nm_busy",  32'(bus.busy), 32'd0);
    check("nm_est_held", 32'(bus.delay_est), 32'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nm_fail_hold", 32'(bus.fail), 32'd1);
    end

    // Restart from FAIL at delay 1: k=0 misses, then four matches -> E0+5.
    pulse_start(1, 1'b0);
    check("nm_restart_fail", 32'(bus.fail), 32'd0);
    check("nm_restart_busy", 32'(bus.busy), 32'd1);
    ticks(5);
    check("d1_locked", 32'(bus.locked), 32'd1);
    check("d1_est",    32'(bus.delay_est), 32'd1);
    check("d1_err0",   32'(bus.err_cnt),   32'(exp_err(0)));

    // Loss of lock: one bad cycle is tolerated.
    corrupt = 1'b1; drive_dly();
    tick();
    corrupt = 1'b0; drive_dly();
    check("ll_single_locked", 32'(bus.locked), 32'd1);
    check("ll_single_err",    32'(bus.err_cnt), 32'(exp_err(1)));
    tick();
    // Two consecutive bad cycles drop lock on the second.
    corrupt = 1'b1; drive_dly();
    tick();
    check("ll_first_bad", 32'(bus.locked), 32'd1);
    tick();
    corrupt = 1'b0; drive_dly();
    check("ll_dropped", 32'(bus.locked), 32'd0);
    check("ll_busy",    32'(bus.busy),   32'd1);
    check("ll_err",     32'(bus.err_cnt), 32'(exp_err(3)));
    // Relock: k=0 misses once, then four matches at k=1.
    ticks(4);
    check("ll_relock_early", 32'(bus.locked), 32'd0);
    tick();
    check("ll_relock", 32'(bus.locked), 32'd1);
    check("ll_relock_est", 32'(bus.delay_est), 32'd1);
    check("ll_err_kept",   32'(bus.err_cnt), 32'(exp_err(3)));

    // Saturation: alternating bad/good never drops lock; count climbs to FF.
    for (int i = 0; i < 300; i++) begin
      corrupt = 1'b1; drive_dly();
      tick();
      corrupt = 1'b0; drive_dly();
      tick();
      if (i == 9) check("sat_err_13", 32'(bus.err_cnt), 32'(exp_err(13)));
    end
    check("sat_locked", 32'(bus.locked), 32'd1);
    check("sat_err",    32'(bus.err_cnt), 32'(exp_err(303)));

    // Asynchronous reset in the middle of a search.
    pulse_start(1, 1'b0);
    tick();
    check("rs_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_busy",   32'(bus.busy),   32'd0);
    check("rs_locked", 32'(bus.locked), 32'd0);
    check("rs_est",    32'(bus.delay_est), 32'd0);
    check("rs_err",    32'(bus.err_cnt),   32'd0);
    tick();
    rst = 1'b0;
    ticks(10);
    check("rs_idle_busy",   32'(bus.busy),   32'd0);
    check("rs_idle_locked", 32'(bus.locked), 32'd0);

    // start on the edge that would lock restarts the search from k=0.
    pulse_start(0, 1'b0);
    ticks(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("sp_busy",   32'(bus.busy),   32'd1);
    check("sp_locked", 32'(bus.locked), 32'd0);
    ticks(3);
    check("sp_not_yet", 32'(bus.locked), 32'd0);
    tick();
    check("sp_locked_after", 32'(bus.locked), 32'd1);
    check("sp_est",          32'(bus.delay_est), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
